router_pkt_reader: RTL and testbench

ROUTER_PKT_READER -- requirements
Module: router_pkt_reader

---
 rtl/router_pkt_reader.sv | 82 ++++++++
 tb/tb_router_pkt_reader.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/router_pkt_reader.sv
// router_pkt_reader: drains a packet FIFO one byte at a time, tracking framing and parity, with consumer timeout flush
module router_pkt_reader (
  input  logic       clock,
  input  logic       reset,
  input  logic       empty,
  input  logic [7:0] data_out,
  input  logic       read_in,
  output logic       fifo_read_enb,
  output logic       valid_out,
  output logic [7:0] data_o,
  output logic       sop_out,
  output logic       eop_out,
  output logic [1:0] dest_addr,
  output logic       pkt_done,
  output logic       parity_err,
  output logic       soft_reset_out,
  output logic       busy
);
  typedef enum logic [1:0] {IDLE, PAYLOAD, PARITY, FLUSH} state_t;
  state_t state, state_n;
  logic       pend, take;
  logic [5:0] len, cnt;
  logic [7:0] acc;
  logic [4:0] tcnt;
  always_comb begin
    take = valid_out & read_in;
    fifo_read_enb = !reset & !empty & !pend & (state != FLUSH) & (!valid_out | take);
    soft_reset_out = valid_out & !read_in & (tcnt == 5'd29);
    sop_out = valid_out & (state == IDLE);
    eop_out = valid_out & (state == PARITY);
    busy = (state != IDLE) | valid_out | pend;
    state_n = state;
    if (soft_reset_out) state_n = FLUSH;
    else if (state == FLUSH) state_n = IDLE;
    else if (take)
      state_n = state == IDLE    ? (data_o[7:2] != 6'd0 ? PAYLOAD : PARITY) :
                state == PAYLOAD ? (6'(cnt + 6'd1) == len ? PARITY : PAYLOAD) : IDLE;
  end
  always_ff @(posedge clock)
    state <= reset ? IDLE : state_n;
  always_ff @(posedge clock) begin
    if (reset) begin
      pend       <= 1'b0;
      valid_out  <= 1'b0;
      data_o     <= 8'h00;
      dest_addr  <= 2'b00;
      len        <= 6'd0;
      cnt        <= 6'd0;
      acc        <= 8'h00;
      tcnt       <= 5'd0;
      pkt_done   <= 1'b0;
      parity_err <= 1'b0;
    end else begin
      pkt_done   <= take & (state == PARITY);
      parity_err <= take & (state == PARITY) & (acc != data_o);
      // timeout edge and the flush cycle both discard everything in flight
      if (soft_reset_out | (state == FLUSH)) begin
        pend      <= 1'b0;
        valid_out <= 1'b0;
        cnt       <= 6'd0;
        acc       <= 8'h00;
        tcnt      <= 5'd0;
      end else begin
        pend <= fifo_read_enb;
        if (pend) begin
          data_o    <= data_out;
          valid_out <= 1'b1;
        end else if (take) valid_out <= 1'b0;
        tcnt <= (valid_out & !read_in) ? 5'(tcnt + 5'd1) : 5'd0;
        if (take & (state == IDLE)) begin
          len       <= data_o[7:2];
          dest_addr <= data_o[1:0];
          acc       <= data_o;
          cnt       <= 6'd0;
        end else if (take & (state == PAYLOAD)) begin
          acc <= acc ^ data_o;
          cnt <= 6'(cnt + 6'd1);
        end
      end
    end
  end
endmodule

// File: tb/tb_router_pkt_reader.sv
// tb_router_pkt_reader: FIFO model plus scoreboard of expected delivered bytes and packet results
module tb_router_pkt_reader;
  logic       clock = 0, reset = 1, empty = 1, read_in = 0;
  logic [7:0] data_out = 8'h00;
  logic       fifo_read_enb, valid_out, sop_out, eop_out, pkt_done, parity_err, soft_reset_out, busy;
  logic [7:0] data_o;
  logic [1:0] dest_addr;

  router_pkt_reader dut (
    .clock(clock), .reset(reset), .empty(empty), .data_out(data_out), .read_in(read_in),
    .fifo_read_enb(fifo_read_enb), .valid_out(valid_out), .data_o(data_o),
    .sop_out(sop_out), .eop_out(eop_out), .dest_addr(dest_addr), .pkt_done(pkt_done),
    .parity_err(parity_err), .soft_reset_out(soft_reset_out), .busy(busy)
  );

  always #5 clock = ~clock;

  logic [7:0] fifo[$];
  logic [9:0] exp_q[$];
  logic [2:0] pkt_q[$];
  int nvec = 0, nerr = 0, ntake = 0;
  bit due = 0, allow_srst = 0;

  always @(posedge clock) if (fifo_read_enb && fifo.size() != 0) data_out <= fifo.pop_front();
  always @(negedge clock) empty <= (fifo.size() == 0);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    nvec++;
    assert (obs === expv) else begin
      nerr++;
      $error("FAIL %s observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  always @(negedge clock) begin
    logic [9:0] e;
    logic [2:0] p;
    if (reset) due = 0;
    else begin
      chk("pkt_done", {31'd0, pkt_done}, {31'd0, due});
      if (pkt_done && due) begin
        if (pkt_q.size() == 0) chk("pkt_q", 32'd0, 32'd1);
        else begin
          p = pkt_q.pop_front();
          chk("parity_err", {31'd0, parity_err}, {31'd0, p[2]});
          chk("dest_addr", {30'd0, dest_addr}, {30'd0, p[1:0]});
        end
      end
      due = 0;
      if (valid_out && read_in) begin
        ntake++;
        if (exp_q.size() == 0) chk("take_q", 32'd0, 32'd1);
        else begin
          e = exp_q.pop_front();
          chk("byte", {22'd0, sop_out, eop_out, data_o}, {22'd0, e});
          due = e[8];
        end
      end
      if (!allow_srst) chk("no_srst", {31'd0, soft_reset_out}, 32'd0);
    end
  end

  task automatic push_b(input logic [7:0] b, input logic s, input logic e, input int gap);
    if (gap > 0) begin
      repeat (gap) @(posedge clock);
      #1;
    end
    fifo.push_back(b);
    exp_q.push_back({s, e, b});
  endtask

  task automatic send(input logic [7:0] hdr, input bit bad, input bit track, input int gap);
    logic [7:0] acc, b;
    acc = hdr;
    push_b(hdr, 1'b1, 1'b0, 0);
    for (int i = 0; i < int'(hdr[7:2]); i++) begin
      b = 8'($urandom);
      acc ^= b;
      push_b(b, 1'b0, 1'b0, gap);
    end
    push_b(acc ^ {7'd0, bad}, 1'b0, 1'b1, gap);
    if (track) pkt_q.push_back({bad, hdr[1:0]});
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 3000 && (exp_q.size() != 0 || pkt_q.size() != 0); i++) @(negedge clock);
    @(negedge clock);
    chk(tag, exp_q.size() + pkt_q.size(), 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    for (int i = 0; i < 40 && !valid_out; i++) @(negedge clock);
    chk(tag, {31'd0, valid_out}, 32'd1);
  endtask

  initial begin
    int n, base;
    send(8'h39, 0, 1, 0);
    repeat (3) @(negedge clock);
    chk("rst_rd_enb", {31'd0, fifo_read_enb}, 32'd0);
    chk("rst_valid", {31'd0, valid_out}, 32'd0);
    chk("rst_data", {24'd0, data_o}, 32'd0);
    chk("rst_dest", {30'd0, dest_addr}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {28'd0, sop_out, eop_out, pkt_done, soft_reset_out}, 32'd0);
    @(posedge clock); #1;
    reset = 0;
    read_in = 1;
    base = ntake;
    drain("good_pkt");
    chk("good_takes", ntake - base, 32'd16);
    chk("good_dest", {30'd0, dest_addr}, 32'd1);

    send(8'h39, 1, 1, 0);
    drain("bad_parity");

    send(8'h02, 0, 1, 0);
    drain("len0");
    chk("len0_dest", {30'd0, dest_addr}, 32'd2);

    send(8'h10, 0, 1, 7);
    drain("stall_pkt");

    read_in = 0;
    allow_srst = 1;
    fifo.push_back(8'h13);
    wait_valid("tout_valid");
    n = 1;
    while (!soft_reset_out && n < 40) begin
      @(negedge clock);
      n++;
    end
    chk("tout_cycle", n, 32'd30);
    @(negedge clock);
    chk("tout_pulse", {31'd0, soft_reset_out}, 32'd0);
    chk("flush_valid", {31'd0, valid_out}, 32'd0);
    chk("flush_busy", {31'd0, busy}, 32'd1);
    @(negedge clock);
    chk("post_flush_busy", {31'd0, busy}, 32'd0);
    allow_srst = 0;

    send(8'h07, 0, 1, 0);
    wait_valid("t29_valid");
    repeat (28) @(negedge clock);
    chk("t29_no_srst", {31'd0, soft_reset_out}, 32'd0);
    @(posedge clock); #1;
    read_in = 1;
    drain("t29_pkt");
    chk("t29_dest", {30'd0, dest_addr}, 32'd3);

    base = ntake;
    send(8'h39, 0, 0, 0);
    for (int i = 0; i < 200 && ntake < base + 6; i++) @(negedge clock);
    chk("rst_mid_takes", ntake - base, 32'd6);
    @(posedge clock); #1;
    reset = 1;
    fifo.delete();
    exp_q.delete();
    @(posedge clock); #1;
    @(negedge clock);
    chk("mid_rst_valid", {31'd0, valid_out}, 32'd0);
    chk("mid_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_rst_dest", {30'd0, dest_addr}, 32'd0);
    @(posedge clock); #1;
    reset = 0;
    send(8'h0D, 0, 1, 0);
    drain("after_rst");
    chk("after_rst_dest", {30'd0, dest_addr}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
